// File: rtl/adder_arbiter_if.sv
// adder_arbiter_if: request, response and status signals of the shared-adder arbiter.
// master = requesters and response consumer; slave = the arbiter.
// Operand and sum buses are declared [0:31] with index 0 as the LSB.
interface adder_arbiter_if #(
    parameter int unsigned TAG_W = 2
);
    logic             r0_valid;
    logic             r0_ready;
    logic [0:31]      r0_a;
    logic [0:31]      r0_b;
    logic             r0_ci;
    logic [1:0]       r0_mode;
    logic [TAG_W-1:0] r0_tag;

    logic             r1_valid;
    logic             r1_ready;
    logic [0:31]      r1_a;
    logic [0:31]      r1_b;
    logic             r1_ci;
    logic [1:0]       r1_mode;
    logic [TAG_W-1:0] r1_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [0:31]      rsp_sum;
    logic             rsp_co;
    logic             rsp_src;
    logic [TAG_W-1:0] rsp_tag;
    logic             busy;

    modport master (
        output r0_valid, r0_a, r0_b, r0_ci, r0_mode, r0_tag,
        output r1_valid, r1_a, r1_b, r1_ci, r1_mode, r1_tag,
        output rsp_ready,
        input  r0_ready, r1_ready,
        input  rsp_valid, rsp_sum, rsp_co, rsp_src, rsp_tag, busy
    );

    modport slave (
        input  r0_valid, r0_a, r0_b, r0_ci, r0_mode, r0_tag,
        input  r1_valid, r1_a, r1_b, r1_ci, r1_mode, r1_tag,
        input  rsp_ready,
        output r0_ready, r1_ready,
        output rsp_valid, rsp_sum, rsp_co, rsp_src, rsp_tag, busy
    );
endinterface

// File: rtl/adder_arbiter.sv
// adder_arbiter: two requesters share one 16-bit adder datapath.
// Modes: 00/11 = 16-bit add, 01 = split 2x8 add, 10 = 32-bit add in two chained passes.
// Define ADDARB_RR_EN for round-robin arbitration; otherwise r0 has fixed priority.
module adder_arbiter #(
    parameter int unsigned TAG_W = 2
) (
    input logic             clk,
    input logic             rst_n,
    adder_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StExec0, StExec1, StResp} state_e;

    state_e           state_q, state_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [31:0]      sum_q, sum_d;
    logic             ci_q, ci_d;
    logic             src_q, src_d;
    logic             co_q, co_d;
    logic             carry_q, carry_d;
    logic [1:0]       mode_q, mode_d;
    logic [TAG_W-1:0] tag_q, tag_d;
`ifdef ADDARB_RR_EN
    logic             rr_ptr_q, rr_ptr_d;
`endif

    logic             grant;
    logic [15:0]      add_a, add_b, add_s;
    logic             add_ci, add_split, add_co;
    logic [8:0]       lo_sum, hi_sum;

    // [0:31] bus (index 0 = LSB) to numeric vector
    function automatic logic [31:0] to_num(input logic [0:31] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[i];
        return r;
    endfunction

    function automatic logic [0:31] to_bus(input logic [31:0] v);
        logic [0:31] r;
        for (int i = 0; i < 32; i++) r[i] = v[i];
        return r;
    endfunction

    // Grant selection and request-ready generation
    always_comb begin
`ifdef ADDARB_RR_EN
        if (bus.r0_valid && bus.r1_valid) grant = rr_ptr_q;
        else                              grant = ~bus.r0_valid;
`else
        grant = ~bus.r0_valid;
`endif
        bus.r0_ready = rst_n & (state_q == StIdle) & bus.r0_valid & ~grant;
        bus.r1_ready = rst_n & (state_q == StIdle) & bus.r1_valid & grant;
    end

    // Shared 16-bit adder; split mode blocks the carry out of bit 7
    always_comb begin
        add_a     = a_q[15:0];
        add_b     = b_q[15:0];
        add_ci    = ci_q;
        add_split = (state_q == StExec0) && (mode_q == 2'b01);
        if (state_q == StExec1) begin
            add_a  = a_q[31:16];
            add_b  = b_q[31:16];
            add_ci = carry_q;
        end
        lo_sum = {1'b0, add_a[7:0]} + {1'b0, add_b[7:0]} + {8'd0, add_ci};
        hi_sum = {1'b0, add_a[15:8]} + {1'b0, add_b[15:8]}
               + {8'd0, (add_split ? 1'b0 : lo_sum[8])};
        add_s  = {hi_sum[7:0], lo_sum[7:0]};
        add_co = hi_sum[8];
    end

    // Next-state and register capture
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        ci_d    = ci_q;
        src_d   = src_q;
        co_d    = co_q;
        carry_d = carry_q;
        mode_d  = mode_q;
        tag_d   = tag_q;
`ifdef ADDARB_RR_EN
        rr_ptr_d = rr_ptr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.r0_valid || bus.r1_valid) begin
                    a_d    = grant ? to_num(bus.r1_a) : to_num(bus.r0_a);
                    b_d    = grant ? to_num(bus.r1_b) : to_num(bus.r0_b);
                    ci_d   = grant ? bus.r1_ci : bus.r0_ci;
                    mode_d = grant ? bus.r1_mode : bus.r0_mode;
                    tag_d  = grant ? bus.r1_tag : bus.r0_tag;
                    src_d  = grant;
`ifdef ADDARB_RR_EN
                    rr_ptr_d = ~grant;
`endif
                    state_d = StExec0;
                end
            end
            StExec0: begin
                sum_d[15:0] = add_s;
                carry_d     = add_co;
                if (mode_q == 2'b10) begin
                    state_d = StExec1;
                end else begin
                    sum_d[31:16] = 16'd0;
                    co_d         = add_co;
                    state_d      = StResp;
                end
            end
            StExec1: begin
                sum_d[31:16] = add_s;
                co_d         = add_co;
                state_d      = StResp;
            end
            StResp: begin
                if (bus.rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Response outputs come straight from the result registers
    always_comb begin
        bus.rsp_valid = (state_q == StResp);
        bus.rsp_sum   = to_bus(sum_q);
        bus.rsp_co    = co_q;
        bus.rsp_src   = src_q;
        bus.rsp_tag   = tag_q;
        bus.busy      = (state_q != StIdle);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            ci_q    <= 1'b0;
            src_q   <= 1'b0;
            co_q    <= 1'b0;
            carry_q <= 1'b0;
            mode_q  <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            ci_q    <= ci_d;
            src_q   <= src_d;
            co_q    <= co_d;
            carry_q <= carry_d;
            mode_q  <= mode_d;
            tag_q   <= tag_d;
        end
    end

`ifdef ADDARB_RR_EN
    // Round-robin pointer; r0 is preferred out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr_q <= 1'b0;
        else        rr_ptr_q <= rr_ptr_d;
    end
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed and randomized checks of adder_arbiter against an arithmetic model.
module tb_adder_arbiter;

    localparam int unsigned TagW = 2;

    typedef struct {
        logic [31:0] sum;
        logic        co;
        logic        src;
        logic [1:0]  tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    adder_arbiter_if #(.TAG_W(TagW)) bus ();

    adder_arbiter #(.TAG_W(TagW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [0:31] to_bus(input logic [31:0] v);
        logic [0:31] r;
        for (int i = 0; i < 32; i++) r[i] = v[i];
        return r;
    endfunction

    function automatic logic [31:0] to_num(input logic [0:31] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[i];
        return r;
    endfunction

    // Reference result {co, sum} computed directly from the operation definitions
    function automatic logic [32:0] ref_add(input logic [1:0] mode, input logic [31:0] a,
                                            input logic [31:0] b, input logic ci);
        logic [32:0] r;
        logic [16:0] s16;
        logic [8:0]  lo, hi;
        case (mode)
            2'b10: r = {1'b0, a} + {1'b0, b} + {32'd0, ci};
            2'b01: begin
                lo = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'd0, ci};
                hi = {1'b0, a[15:8]} + {1'b0, b[15:8]};
                r  = {hi[8], 16'd0, hi[7:0], lo[7:0]};
            end
            default: begin
                s16 = {1'b0, a[15:0]} + {1'b0, b[15:0]} + {16'd0, ci};
                r   = {s16[16], 16'd0, s16[15:0]};
            end
        endcase
        return r;
    endfunction

    function automatic logic rdy(input int s);
        return (s == 0) ? bus.r0_ready : bus.r1_ready;
    endfunction

    task automatic set_req(input int s, input logic v, input logic [31:0] a, input logic [31:0] b,
                           input logic ci, input logic [1:0] mode, input logic [1:0] tag);
        if (s == 0) begin
            bus.r0_valid = v; bus.r0_a = to_bus(a); bus.r0_b = to_bus(b);
            bus.r0_ci = ci; bus.r0_mode = mode; bus.r0_tag = tag;
        end else begin
            bus.r1_valid = v; bus.r1_a = to_bus(a); bus.r1_b = to_bus(b);
            bus.r1_ci = ci; bus.r1_mode = mode; bus.r1_tag = tag;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request from requester s with rsp_ready held high; checks latency and result
    task automatic run_single(input int s, input logic [31:0] a, input logic [31:0] b,
                              input logic ci, input logic [1:0] mode, input logic [1:0] tag);
        logic [32:0] e;
        int w = 0;
        int lat = 0;
        e = ref_add(mode, a, b, ci);
        bus.rsp_ready = 1'b1;
        set_req(s, 1'b1, a, b, ci, mode, tag);
        #1;
        while (rdy(s) !== 1'b1 && w < 20) begin tick(); w++; end
        check_eq("single_grant", 64'(w < 20), 64'd1);
        tick();
        set_req(s, 1'b0, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00);
        while (bus.rsp_valid !== 1'b1 && lat < 10) begin tick(); lat++; end
        check_eq("single_latency", 64'(lat), (mode == 2'b10) ? 64'd2 : 64'd1);
        check_eq("single_sum", 64'(to_num(bus.rsp_sum)), 64'(e[31:0]));
        check_eq("single_co", 64'(bus.rsp_co), 64'(e[32]));
        check_eq("single_src", 64'(bus.rsp_src), 64'(s));
        check_eq("single_tag", 64'(bus.rsp_tag), 64'(tag));
        check_eq("single_busy", 64'(bus.busy), 64'd1);
        tick();
        check_eq("single_idle", 64'({bus.busy, bus.rsp_valid}), 64'd0);
    endtask

    // Both requesters issue n0/n1 requests back to back; responses go through a scoreboard
    task automatic run_stream(input int n0, input int n1, input bit stall, input bit order_chk);
        int          left[2];
        logic [31:0] ca[2], cb[2];
        logic        cci[2];
        logic [1:0]  cm[2], ct[2];
        bit          acc[2];
        exp_t        q[$];
        exp_t        x;
        int          order[$];
        int          e_left[2];
        int          last_acc = -1;
        logic [1:0]  last_mode = 2'b00;
        int          cyc = 0;
        int          got = 0;
        int          total = n0 + n1;
        int          pick;
        int          p = 0;
        logic [32:0] r;
        left[0] = n0;
        left[1] = n1;
        for (int s = 0; s < 2; s++) begin
            ca[s] = $urandom; cb[s] = $urandom; cci[s] = 1'($urandom_range(0, 1));
            cm[s] = 2'($urandom_range(0, 3)); ct[s] = 2'($urandom_range(0, 3));
            set_req(s, left[s] > 0, ca[s], cb[s], cci[s], cm[s], ct[s]);
        end
        bus.rsp_ready = 1'b1;
        #1;
        while (got < total && cyc < 3000) begin
            check_eq("one_ready", 64'(bus.r0_ready & bus.r1_ready), 64'd0);
            for (int s = 0; s < 2; s++) begin
                acc[s] = 1'b0;
                if (rdy(s) === 1'b1) begin
                    acc[s] = 1'b1;
                    r = ref_add(cm[s], ca[s], cb[s], cci[s]);
                    x.sum = r[31:0]; x.co = r[32]; x.src = 1'(s); x.tag = ct[s];
                    q.push_back(x);
                    order.push_back(s);
                    if (!stall && last_acc >= 0)
                        check_eq("issue_interval", 64'(cyc - last_acc),
                                 (last_mode == 2'b10) ? 64'd4 : 64'd3);
                    last_acc  = cyc;
                    last_mode = cm[s];
                end
            end
            if (bus.rsp_valid === 1'b1) begin
                check_eq("rsp_ready_low", 64'({bus.r0_ready, bus.r1_ready}), 64'd0);
                if (q.size() == 0) begin
                    check_eq("rsp_unexpected", 64'd1, 64'(q.size()));
                end else begin
                    check_eq("stream_sum", 64'(to_num(bus.rsp_sum)), 64'(q[0].sum));
                    check_eq("stream_co", 64'(bus.rsp_co), 64'(q[0].co));
                    check_eq("stream_src", 64'(bus.rsp_src), 64'(q[0].src));
                    check_eq("stream_tag", 64'(bus.rsp_tag), 64'(q[0].tag));
                    if (bus.rsp_ready) begin
                        void'(q.pop_front());
                        got++;
                    end
                end
            end
            tick();
            cyc++;
            for (int s = 0; s < 2; s++) begin
                if (acc[s]) begin
                    left[s]--;
                    ca[s] = $urandom; cb[s] = $urandom; cci[s] = 1'($urandom_range(0, 1));
                    cm[s] = 2'($urandom_range(0, 3)); ct[s] = 2'($urandom_range(0, 3));
                    set_req(s, left[s] > 0, ca[s], cb[s], cci[s], cm[s], ct[s]);
                end
            end
            if (stall) bus.rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
        end
        bus.rsp_ready = 1'b1;
        check_eq("stream_done", 64'(got), 64'(total));
        if (order_chk && order.size() == total) begin
            e_left[0] = n0;
            e_left[1] = n1;
            for (int k = 0; k < total; k++) begin
                if (e_left[0] > 0 && e_left[1] > 0) begin
`ifdef ADDARB_RR_EN
                    pick = p;
`else
                    pick = 0;
`endif
                end else begin
                    pick = (e_left[0] > 0) ? 0 : 1;
                end
                p = 1 - pick;
                e_left[pick]--;
                check_eq("grant_order", 64'(order[k]), 64'(pick));
            end
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        logic [31:0] held_sum;
        logic [1:0]  held_tag;
        logic [32:0] e;
        int          w;
        set_req(0, 1'b1, 32'h1, 32'h1, 1'b0, 2'b00, 2'b00);
        set_req(1, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 2'b00);
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        // Reset values, with a request pending so ready gating is visible
        check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check_eq("rst_busy", 64'(bus.busy), 64'd0);
        check_eq("rst_sum", 64'(to_num(bus.rsp_sum)), 64'd0);
        check_eq("rst_co_src_tag", 64'({bus.rsp_co, bus.rsp_src, bus.rsp_tag}), 64'd0);
        check_eq("rst_ready", 64'({bus.r0_ready, bus.r1_ready}), 64'd0);
        set_req(0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 2'b00);
        rst_n = 1'b1;
        tick();

        run_single(0, 32'h0000FFFF, 32'h00000001, 1'b0, 2'b00, 2'd1);
        run_single(1, 32'h000001FF, 32'h00000101, 1'b1, 2'b01, 2'd2);
        run_single(0, 32'h0001FFFF, 32'h00000001, 1'b0, 2'b10, 2'd3);
        run_single(1, 32'hFFFFFFFF, 32'h00000000, 1'b1, 2'b10, 2'd0);
        run_single(0, $urandom, $urandom, 1'b1, 2'b11, 2'd2);

        // Stalled response: outputs hold, no grants while r1 waits
        bus.rsp_ready = 1'b0;
        e = ref_add(2'b00, 32'h00001234, 32'h00000F0F, 1'b1);
        set_req(0, 1'b1, 32'h00001234, 32'h00000F0F, 1'b1, 2'b00, 2'd2);
        #1;
        check_eq("stall_grant", 64'(bus.r0_ready), 64'd1);
        tick();
        set_req(0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 2'b00);
        set_req(1, 1'b1, 32'h00000010, 32'h00000020, 1'b0, 2'b00, 2'd1);
        w = 0;
        while (bus.rsp_valid !== 1'b1 && w < 10) begin tick(); w++; end
        held_sum = e[31:0];
        held_tag = 2'd2;
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_sum", 64'(to_num(bus.rsp_sum)), 64'(held_sum));
            check_eq("stall_tag", 64'(bus.rsp_tag), 64'(held_tag));
            check_eq("stall_ready", 64'({bus.r0_ready, bus.r1_ready}), 64'd0);
            check_eq("stall_busy", 64'({bus.busy, bus.rsp_valid}), 64'd3);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        check_eq("stall_release_busy", 64'(bus.busy), 64'd0);
        check_eq("stall_release_r1", 64'(bus.r1_ready), 64'd1);
        tick();
        set_req(1, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 2'b00);
        w = 0;
        while (bus.rsp_valid !== 1'b1 && w < 10) begin tick(); w++; end
        check_eq("stall_next_sum", 64'(to_num(bus.rsp_sum)), 64'h30);
        check_eq("stall_next_src", 64'(bus.rsp_src), 64'd1);
        tick();

        // Reset in the middle of a chained add
        set_req(0, 1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 2'b10, 2'd3);
        #1;
        check_eq("rst_mid_grant", 64'(bus.r0_ready), 64'd1);
        tick();
        set_req(0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 2'b00);
        tick();
        check_eq("rst_mid_busy", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_outs", 64'({bus.busy, bus.rsp_valid, bus.rsp_co, bus.rsp_src,
                                      bus.rsp_tag}), 64'd0);
        check_eq("rst_mid_sum", 64'(to_num(bus.rsp_sum)), 64'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("rst_mid_no_rsp", 64'(bus.rsp_valid), 64'd0);
        end
        run_single(1, 32'h00010000, 32'h0000FFFF, 1'b1, 2'b10, 2'd1);

        // Arbitration order from a clean reset, then a randomized stalled stream
        pulse_reset();
        run_stream(4, 4, 1'b0, 1'b1);
        run_stream(30, 30, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
